// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and RAM signal bundle for mem_arbiter
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              stall;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
      output if_rdata, if_valid, dm_rdata, dm_valid, stall,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
      input  if_rdata, if_valid, dm_rdata, dm_valid, stall,
             ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one single-port RAM (round robin under MEM_ARB_RR_EN)
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int RAM_LAT = 1
) (
   input logic          clka,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] BUSY_IF  = 2'd1;
   localparam logic [1:0] BUSY_DM  = 2'd2;
   localparam logic [3:0] CNT_LOAD = 4'(RAM_LAT - 1);

   logic [1:0]        state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic              op_we;
   logic              grant_dm;
   logic              issue;
   logic              done;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
   logic last_grant;   // 1: data port won the previous issue

   // remember which port was granted on every issue
   always_ff @(posedge clka) begin
      if (rst)        last_grant <= 1'b0;
      else if (issue) last_grant <= grant_dm;
   end

   assign grant_dm = bus.dm_req & (~bus.if_req | ~last_grant);
`else
   assign grant_dm = bus.dm_req;
`endif

   // issue happens only from IDLE; completion when the latency count runs out
   always_comb begin
      issue = (state == IDLE) && (bus.dm_req || bus.if_req) && !rst;
      done  = (state != IDLE) && (cnt == 4'd0) && !rst;
   end

   // next-state and latency counter
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (issue) begin
               state_nx = grant_dm ? BUSY_DM : BUSY_IF;
               cnt_nx   = CNT_LOAD;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (cnt == 4'd0) state_nx = IDLE;
            else             cnt_nx   = cnt - 4'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   // state registers; a write flag is kept so dm_rdata stays 0 on write completion
   always_ff @(posedge clka) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_we <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (issue) op_we <= grant_dm & bus.dm_we;
      end
   end

   // RAM drive is combinational in the issue cycle and zero otherwise
   always_comb begin
      sel_addr      = grant_dm ? bus.dm_addr : bus.if_addr;
      sel_wdata     = grant_dm ? bus.dm_wdata : '0;
      bus.ram_en    = issue;
      bus.ram_we    = issue & grant_dm & bus.dm_we;
      bus.ram_addr  = issue ? sel_addr : '0;
      bus.ram_wdata = issue ? sel_wdata : '0;
   end

   // completion pulses, returned data and pipeline stall
   always_comb begin
      bus.if_valid = done && (state == BUSY_IF);
      bus.dm_valid = done && (state == BUSY_DM);
      bus.if_rdata = bus.if_valid ? bus.ram_rdata : '0;
      bus.dm_rdata = (bus.dm_valid && !op_we) ? bus.ram_rdata : '0;
      bus.stall    = (bus.if_req & ~bus.if_valid) | (bus.dm_req & ~bus.dm_valid);
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (RAM_LAT 1 and 3 instances)
module tb_mem_arbiter;
   logic clka = 1'b0;
   logic rst  = 1'b1;
   logic mem_clr = 1'b1;

   always #5 clka = ~clka;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) u_dut1 (.clka(clka), .rst(rst), .bus(b1));
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) u_dut3 (.clka(clka), .rst(rst), .bus(b3));

   // RAM models: written words overlay a fixed address-derived background pattern
   logic        wf1 [0:255];
   logic [31:0] wv1 [0:255];
   logic        wf3 [0:255];
   logic [31:0] wv3 [0:255];
   logic [31:0] pipe1;
   logic [31:0] pipe3 [0:2];

   function automatic logic [31:0] init_val(input logic [7:0] idx);
      case (idx)
         8'd16:   return 32'h2008_0005;
         8'd17:   return 32'h0BAD_F00D;
         8'd128:  return 32'h1234_5678;
         default: return ({24'd0, idx} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      endcase
   endfunction

   function automatic logic [31:0] rd1(input logic [7:0] idx);
      return wf1[idx] ? wv1[idx] : init_val(idx);
   endfunction

   function automatic logic [31:0] rd3(input logic [7:0] idx);
      return wf3[idx] ? wv3[idx] : init_val(idx);
   endfunction

   always @(posedge clka) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) begin
            wf1[i] <= 1'b0;
            wf3[i] <= 1'b0;
         end
      end else begin
         if (b1.ram_en) begin
            if (b1.ram_we) begin
               wf1[b1.ram_addr[9:2]] <= 1'b1;
               wv1[b1.ram_addr[9:2]] <= b1.ram_wdata;
            end else begin
               pipe1 <= rd1(b1.ram_addr[9:2]);
            end
         end
         if (b3.ram_en) begin
            if (b3.ram_we) begin
               wf3[b3.ram_addr[9:2]] <= 1'b1;
               wv3[b3.ram_addr[9:2]] <= b3.ram_wdata;
            end else begin
               pipe3[0] <= rd3(b3.ram_addr[9:2]);
            end
         end
      end
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   assign b1.ram_rdata = pipe1;
   assign b3.ram_rdata = pipe3[2];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic nxt();
      @(posedge clka);
      #1;
   endtask

   task automatic smp();
      @(negedge clka);
   endtask

   initial begin
      logic [31:0] gexp [0:3];
      int          g;
      bit          busy, own_dm, op_we, last_dm, g_dm;
      bit          exp_ifv, exp_dmv, exp_en, exp_we;
      int          issue_t;
      logic [31:0] exp_rd, exp_ifd, exp_dmd, exp_addr;

      b1.if_req = 1'b1; b1.if_addr = 32'h40;
      b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
      b3.if_req = 1'b0; b3.if_addr = '0;
      b3.dm_req = 1'b0; b3.dm_we = 1'b0; b3.dm_addr = '0; b3.dm_wdata = '0;

      // reset held with a pending fetch
      repeat (3) begin
         smp();
         check("rst_ram_en",   32'(b1.ram_en),   32'd0);
         check("rst_if_valid", 32'(b1.if_valid), 32'd0);
         check("rst_dm_valid", 32'(b1.dm_valid), 32'd0);
         check("rst_stall",    32'(b1.stall),    32'd1);
         nxt();
         mem_clr = 1'b0;
      end
      rst = 1'b0;

      // single fetch, first IDLE cycle
      smp();
      check("fetch_issue_en",   32'(b1.ram_en),   32'd1);
      check("fetch_issue_addr", b1.ram_addr,      32'h40);
      check("fetch_issue_we",   32'(b1.ram_we),   32'd0);
      check("fetch_issue_stall",32'(b1.stall),    32'd1);
      nxt();
      smp();
      check("fetch_valid",  32'(b1.if_valid), 32'd1);
      check("fetch_rdata",  b1.if_rdata,      32'h2008_0005);
      check("fetch_en_off", 32'(b1.ram_en),   32'd0);
      check("fetch_stall",  32'(b1.stall),    32'd0);
      nxt();

      // collision: data write first, then fetch
      b1.if_addr = 32'h44;
      b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 32'h100; b1.dm_wdata = 32'hDEAD_BEEF;
      smp();
      check("col_en",    32'(b1.ram_en), 32'd1);
      check("col_we",    32'(b1.ram_we), 32'd1);
      check("col_addr",  b1.ram_addr,    32'h100);
      check("col_wdata", b1.ram_wdata,   32'hDEAD_BEEF);
      check("col_stall0",32'(b1.stall),  32'd1);
      nxt();
      smp();
      check("col_dm_valid", 32'(b1.dm_valid), 32'd1);
      check("col_dm_rdata", b1.dm_rdata,      32'd0);
      check("col_if_wait",  32'(b1.if_valid), 32'd0);
      check("col_stall1",   32'(b1.stall),    32'd1);
      nxt();
      b1.dm_req = 1'b0; b1.dm_we = 1'b0;
      smp();
      check("col_if_en",   32'(b1.ram_en), 32'd1);
      check("col_if_addr", b1.ram_addr,    32'h44);
      check("col_stall2",  32'(b1.stall),  32'd1);
      check("col_written", wv1[64],        32'hDEAD_BEEF);
      nxt();
      smp();
      check("col_if_valid", 32'(b1.if_valid), 32'd1);
      check("col_if_rdata", b1.if_rdata,      32'h0BAD_F00D);
      check("col_stall3",   32'(b1.stall),    32'd0);
      nxt();
      b1.if_req = 1'b0;

      // reset during the busy cycle of a load
      b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h200;
      smp();
      check("mid_issue", 32'(b1.ram_en), 32'd1);
      nxt();
      rst = 1'b1;
      smp();
      check("mid_no_valid", 32'(b1.dm_valid), 32'd0);
      check("mid_rdata",    b1.dm_rdata,      32'd0);
      check("mid_en",       32'(b1.ram_en),   32'd0);
      nxt();
      rst = 1'b0; b1.dm_req = 1'b0;
      smp();
      check("post_en",    32'(b1.ram_en),   32'd0);
      check("post_dmv",   32'(b1.dm_valid), 32'd0);
      check("post_ifv",   32'(b1.if_valid), 32'd0);
      check("post_stall", 32'(b1.stall),    32'd0);
      check("post_addr",  b1.ram_addr,      32'd0);
      nxt();
      b1.if_req = 1'b1; b1.if_addr = 32'h48;
      smp();
      check("post_idle_issue", 32'(b1.ram_en), 32'd1);
      nxt();
      smp();
      check("post_if_rdata", b1.if_rdata, init_val(8'd18));
      nxt();

      // both requests held for four grants
      b1.if_addr = 32'h20;
      b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h10;
      for (int k = 0; k < 4; k++) gexp[k] = (RR && k[0]) ? 32'h20 : 32'h10;
      g = 0;
      for (int c = 0; c < 20 && g < 4; c++) begin
         smp();
         if (b1.ram_en) begin
            check($sformatf("grant_%0d", g), b1.ram_addr, gexp[g]);
            g++;
         end
         nxt();
      end
      check("grant_count", 32'(g), 32'd4);
      b1.if_req = 1'b0; b1.dm_req = 1'b0;
      repeat (3) nxt();

      // RAM_LAT=3 load
      b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 32'h200;
      smp();
      check("l3_issue", 32'(b3.ram_en), 32'd1);
      check("l3_addr",  b3.ram_addr,    32'h200);
      nxt();
      for (int k = 0; k < 2; k++) begin
         smp();
         check("l3_wait_en",  32'(b3.ram_en),   32'd0);
         check("l3_wait_dmv", 32'(b3.dm_valid), 32'd0);
         nxt();
      end
      smp();
      check("l3_valid", 32'(b3.dm_valid), 32'd1);
      check("l3_rdata", b3.dm_rdata,      32'h1234_5678);
      nxt();
      b3.dm_req = 1'b0;
      rst = 1'b1;
      nxt();
      rst = 1'b0;

      // random traffic on the RAM_LAT=3 instance against a timeline model
      busy = 1'b0; own_dm = 1'b0; op_we = 1'b0; last_dm = 1'b0; issue_t = 0; exp_rd = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         smp();
         exp_ifv = 1'b0; exp_dmv = 1'b0; exp_en = 1'b0; exp_we = 1'b0;
         exp_ifd = '0; exp_dmd = '0; g_dm = 1'b0;
         if (busy && cyc == issue_t + 3) begin
            if (own_dm) begin
               exp_dmv = 1'b1;
               exp_dmd = op_we ? 32'd0 : exp_rd;
            end else begin
               exp_ifv = 1'b1;
               exp_ifd = exp_rd;
            end
         end else if (!busy && (b3.if_req || b3.dm_req)) begin
            exp_en = 1'b1;
            if (b3.dm_req && b3.if_req) g_dm = RR ? !last_dm : 1'b1;
            else                        g_dm = b3.dm_req;
            exp_addr = g_dm ? b3.dm_addr : b3.if_addr;
            exp_we   = g_dm && b3.dm_we;
            check("rnd_addr", b3.ram_addr,    exp_addr);
            check("rnd_we",   32'(b3.ram_we), 32'(exp_we));
            if (exp_we) check("rnd_wdata", b3.ram_wdata, b3.dm_wdata);
         end
         check("rnd_en",       32'(b3.ram_en),   32'(exp_en));
         check("rnd_if_valid", 32'(b3.if_valid), 32'(exp_ifv));
         check("rnd_dm_valid", 32'(b3.dm_valid), 32'(exp_dmv));
         check("rnd_if_rdata", b3.if_rdata,      exp_ifd);
         check("rnd_dm_rdata", b3.dm_rdata,      exp_dmd);
         check("rnd_stall",    32'(b3.stall),
               32'((b3.if_req && !exp_ifv) || (b3.dm_req && !exp_dmv)));
         if (exp_ifv || exp_dmv) busy = 1'b0;
         if (exp_en) begin
            busy    = 1'b1;
            issue_t = cyc;
            own_dm  = g_dm;
            op_we   = exp_we;
            last_dm = g_dm;
            exp_rd  = exp_we ? 32'd0 : rd3(exp_addr[9:2]);
         end
         nxt();
         if (exp_ifv || !b3.if_req) begin
            b3.if_req  = exp_ifv ? ($urandom_range(1, 0) == 1) : ($urandom_range(2, 0) == 0);
            b3.if_addr = 32'($urandom_range(63, 0)) << 2;
         end
         if (exp_dmv || !b3.dm_req) begin
            b3.dm_req   = exp_dmv ? ($urandom_range(1, 0) == 1) : ($urandom_range(2, 0) == 0);
            b3.dm_we    = ($urandom_range(1, 0) == 1);
            b3.dm_addr  = 32'($urandom_range(63, 0)) << 2;
            b3.dm_wdata = $urandom;
         end
      end
      b3.if_req = 1'b0; b3.dm_req = 1'b0;
      repeat (5) nxt();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
